// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage: state encoding,
// per-stage payload widths used by the core to size each boundary, and
// the state-to-occupancy decode.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    // Concatenated field widths of each stage boundary register.
    localparam int IF_W = 64;
    localparam int ID_W = 96;
    localparam int EX_W = 80;
    localparam int WB_W = 40;

    // Number of payloads held in a given state.
    function automatic logic [1:0] occ_of(pipe_state_e s);
        logic [1:0] n;
        n = 2'd0;
        case (s)
            ST_FULL: n = 2'd1;
            ST_SKID: n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// One payload register with load enable. Data only, no reset: validity
// is tracked by the owning stage's state flops.
module pipe_entry #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture the payload when the stage asks for it.
    always_ff @(posedge clk) begin
        if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage.sv
// Elastic pipeline stage register with valid/ready handshakes on both
// sides, synchronous flush to a bubble, and an optional skid entry.
//
// Handshake: a payload moves across a port on a clock edge where both
// valid and ready are high. Valid never depends on ready on the same
// port. With SKID=1, in_ready comes from state flops only; with SKID=0,
// in_ready is combinational from out_ready so a full stage can pass
// through at one payload per cycle.
//
// The state is exposed on state_dbg for observation.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int               SKID   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output pipe_state_e      state_dbg
);

    pipe_state_e      state;
    pipe_state_e      state_nxt;
    logic             xfer_in;
    logic             xfer_out;
    logic             load_main;
    logic             main_from_skid;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    assign xfer_in   = in_valid & in_ready;
    assign xfer_out  = out_valid & out_ready;
    assign out_valid = (state != ST_EMPTY);
    assign out_data  = out_valid ? main_q : BUBBLE;
    assign occupancy = occ_of(state);
    assign state_dbg = state;
    assign main_d    = main_from_skid ? skid_q : in_data;

    // State register; only the state is reset, the data entries are not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and main-entry load decode; flush overrides everything.
    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (xfer_in) begin
                    state_nxt = ST_FULL;
                    load_main = 1'b1;
                end
            end
            ST_FULL: begin
                if (xfer_in && xfer_out) begin
                    load_main = 1'b1;
                end else if (xfer_out) begin
                    state_nxt = ST_EMPTY;
                end else if (xfer_in) begin
                    // Only reachable with a skid entry; without one, a
                    // full stage accepts only while draining.
                    if (SKID != 0) begin
                        state_nxt = ST_SKID;
                    end else begin
                        load_main = 1'b1;
                    end
                end
            end
            ST_SKID: begin
                if (xfer_out) begin
                    state_nxt      = ST_FULL;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        if (flush) begin
            state_nxt = ST_EMPTY;
        end
    end

    pipe_entry #(.WIDTH(WIDTH)) u_main (
        .clk  (clk),
        .load (load_main),
        .d    (main_d),
        .q    (main_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic load_skid;
            // The skid entry fills when a full stage accepts but cannot drain.
            assign load_skid = (state == ST_FULL) & xfer_in & ~xfer_out;
            assign in_ready  = (state != ST_SKID);
            pipe_entry #(.WIDTH(WIDTH)) u_skid (
                .clk  (clk),
                .load (load_skid),
                .d    (in_data),
                .q    (skid_q)
            );
        end else begin : g_noskid
            assign in_ready = ~out_valid | out_ready;
            assign skid_q   = in_data;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: one skid-mode and one single-entry instance,
// WIDTH=8, BUBBLE=8'hA5.
module tb_pipe_stage;
    import pipe_pkg::*;

    localparam int         W   = 8;
    localparam logic [7:0] BUB = 8'hA5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // skid-mode instance signals
    logic        s_flush, s_iv, s_ordy;
    logic [7:0]  s_d;
    logic        s_ir, s_ov;
    logic [7:0]  s_od;
    logic [1:0]  s_occ;
    pipe_state_e s_dbg;

    // single-entry instance signals
    logic        ns_flush, ns_iv, ns_ordy;
    logic [7:0]  ns_d;
    logic        ns_ir, ns_ov;
    logic [7:0]  ns_od;
    logic [1:0]  ns_occ;
    pipe_state_e ns_dbg;

    pipe_stage #(.WIDTH(W), .BUBBLE(BUB), .SKID(1)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (s_flush),
        .in_valid  (s_iv),
        .in_ready  (s_ir),
        .in_data   (s_d),
        .out_valid (s_ov),
        .out_ready (s_ordy),
        .out_data  (s_od),
        .occupancy (s_occ),
        .state_dbg (s_dbg)
    );

    pipe_stage #(.WIDTH(W), .BUBBLE(BUB), .SKID(0)) u_noskid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (ns_flush),
        .in_valid  (ns_iv),
        .in_ready  (ns_ir),
        .in_data   (ns_d),
        .out_valid (ns_ov),
        .out_ready (ns_ordy),
        .out_data  (ns_od),
        .occupancy (ns_occ),
        .state_dbg (ns_dbg)
    );

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];   // scoreboard of accepted payloads
    logic [W-1:0] mdl_q[$];   // reference FIFO model for random phase

    typedef struct {
        logic       flush;
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       ov;
        logic [7:0] od;
        logic       ir;
        logic [1:0] occ;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic fl, input logic iv, input logic [7:0] d,
                                input logic ordy, input logic ov, input logic [7:0] od,
                                input logic ir, input logic [1:0] occ);
        vec_t v;
        v.flush = fl; v.iv = iv; v.d = d; v.ordy = ordy;
        v.ov = ov; v.od = od; v.ir = ir; v.occ = occ;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle on the skid instance, check state-based outputs
    // before the next edge, then update the scoreboard.
    task automatic run_cycle(input vec_t v, input string tag);
        logic [7:0] e;
        tick();
        s_flush = v.flush; s_iv = v.iv; s_d = v.d; s_ordy = v.ordy;
        @(negedge clk);
        check($sformatf("%s out_valid", tag), 32'(s_ov),  32'(v.ov));
        check($sformatf("%s out_data", tag),  32'(s_od),  32'(v.od));
        check($sformatf("%s in_ready", tag),  32'(s_ir),  32'(v.ir));
        check($sformatf("%s occupancy", tag), 32'(s_occ), 32'(v.occ));
        if (s_ov && v.ordy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s sb_unexpected: got %0h expected none", tag, s_od);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("%s sb_data", tag), 32'(s_od), 32'(e));
            end
        end
        if (v.flush) exp_q.delete();
        else if (v.iv && v.ir) exp_q.push_back(v.d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        vec_t v;
        logic       fl, iv, ordy;
        logic [7:0] d;
        int         n;
        logic       ns_exp_v[5];
        logic [7:0] ns_exp_d[5];

        s_flush = 0; s_iv = 0; s_d = 0; s_ordy = 1;
        ns_flush = 0; ns_iv = 0; ns_d = 0; ns_ordy = 1;

        // reset / idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst out_valid", 32'(s_ov), 32'(0));
        check("rst out_data",  32'(s_od), 32'(BUB));
        check("rst in_ready",  32'(s_ir), 32'(1));
        check("rst occupancy", 32'(s_occ), 32'(0));
        check("rst state",     32'(s_dbg), 32'(ST_EMPTY));
        check("rst ns out_data", 32'(ns_od), 32'(BUB));
        rst_n = 1'b1;

        // flush, iv, d, ordy | ov, od, ir, occ
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, BUB,   1, 0));
        // streaming 1,2,3
        vecs.push_back(mk(0, 1, 8'h01, 1, 0, BUB,   1, 0));
        vecs.push_back(mk(0, 1, 8'h02, 1, 1, 8'h01, 1, 1));
        vecs.push_back(mk(0, 1, 8'h03, 1, 1, 8'h02, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 8'h03, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, BUB,   1, 0));
        // back-pressure: out_ready low for 3 cycles once 11 is at the head
        vecs.push_back(mk(0, 1, 8'h11, 1, 0, BUB,   1, 0));
        vecs.push_back(mk(0, 1, 8'h12, 0, 1, 8'h11, 1, 1));
        vecs.push_back(mk(0, 1, 8'h13, 0, 1, 8'h11, 0, 2));
        vecs.push_back(mk(0, 1, 8'h13, 0, 1, 8'h11, 0, 2));
        vecs.push_back(mk(0, 1, 8'h13, 1, 1, 8'h11, 0, 2));
        vecs.push_back(mk(0, 1, 8'h13, 1, 1, 8'h12, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 8'h13, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, BUB,   1, 0));
        // flush with both entries held, 07 presented alongside
        vecs.push_back(mk(0, 1, 8'h21, 0, 0, BUB,   1, 0));
        vecs.push_back(mk(0, 1, 8'h22, 0, 1, 8'h21, 1, 1));
        vecs.push_back(mk(1, 1, 8'h07, 0, 1, 8'h21, 0, 2));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, BUB,   1, 0));
        // flush while in_ready=1 and an output transfer completes
        vecs.push_back(mk(0, 1, 8'h31, 1, 0, BUB,   1, 0));
        vecs.push_back(mk(1, 1, 8'h07, 1, 1, 8'h31, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, BUB,   1, 0));
        vecs.push_back(mk(0, 1, 8'h41, 1, 0, BUB,   1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 8'h41, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, BUB,   1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            run_cycle(vecs[i], $sformatf("vec%0d", i));
        end

        // random traffic against a two-deep FIFO model
        for (int i = 0; i < 300; i++) begin
            fl   = ($urandom_range(0, 19) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            d    = 8'($urandom_range(0, 255));
            n    = mdl_q.size();
            v = mk(fl, iv, d, ordy, (n > 0), (n > 0) ? mdl_q[0] : BUB, (n < 2), 2'(n));
            run_cycle(v, "rand");
            if (fl) begin
                mdl_q.delete();
            end else begin
                if (ordy && n > 0) void'(mdl_q.pop_front());
                if (iv && n < 2) mdl_q.push_back(d);
            end
        end
        for (int i = 0; i < 3; i++) begin
            n = mdl_q.size();
            v = mk(0, 0, 8'h00, 1, (n > 0), (n > 0) ? mdl_q[0] : BUB, (n < 2), 2'(n));
            run_cycle(v, "drain");
            if (n > 0) void'(mdl_q.pop_front());
        end
        check("sb drained", 32'(exp_q.size()), 32'(0));
        tick();
        s_iv = 0; s_ordy = 1; s_flush = 0;

        // single-entry: combinational ready follows out_ready
        tick();
        ns_iv = 1; ns_d = 8'h05; ns_ordy = 0;
        #1 check("ns ready empty", 32'(ns_ir), 32'(1));
        tick();
        ns_iv = 0;
        #1 check("ns held valid", 32'(ns_ov), 32'(1));
        check("ns held data", 32'(ns_od), 32'(8'h05));
        check("ns held occ", 32'(ns_occ), 32'(1));
        check("ns ready low", 32'(ns_ir), 32'(0));
        ns_ordy = 1;
        #1 check("ns ready follows hi", 32'(ns_ir), 32'(1));
        ns_ordy = 0;
        #1 check("ns ready follows lo", 32'(ns_ir), 32'(0));
        ns_iv = 1; ns_d = 8'h06; ns_ordy = 1;
        #1 check("ns ready passthru", 32'(ns_ir), 32'(1));
        tick();
        ns_iv = 0; ns_ordy = 0;
        #1 check("ns replace data", 32'(ns_od), 32'(8'h06));
        check("ns replace occ", 32'(ns_occ), 32'(1));
        ns_ordy = 1;
        tick();
        #1 check("ns drained valid", 32'(ns_ov), 32'(0));
        check("ns drained data", 32'(ns_od), 32'(BUB));

        // single-entry streaming 1,2,3
        ns_exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        ns_exp_d = '{BUB, 8'h01, 8'h02, 8'h03, BUB};
        for (int k = 0; k < 5; k++) begin
            tick();
            ns_iv = (k < 3); ns_d = 8'(k + 1); ns_ordy = 1;
            #1 check($sformatf("ns stream%0d valid", k), 32'(ns_ov), 32'(ns_exp_v[k]));
            check($sformatf("ns stream%0d data", k), 32'(ns_od), 32'(ns_exp_d[k]));
        end

        // single-entry flush drops the payload presented with it
        tick();
        ns_iv = 1; ns_d = 8'h08; ns_ordy = 0;
        tick();
        ns_flush = 1; ns_d = 8'h07;
        #1 check("ns pre-flush data", 32'(ns_od), 32'(8'h08));
        tick();
        ns_flush = 0; ns_iv = 0; ns_ordy = 1;
        #1 check("ns flush valid", 32'(ns_ov), 32'(0));
        check("ns flush occ", 32'(ns_occ), 32'(0));
        tick();
        #1 check("ns flush no 07", 32'(ns_ov), 32'(0));

        // asynchronous reset with both skid entries held
        tick();
        s_iv = 1; s_d = 8'h51; s_ordy = 0;
        tick();
        s_d = 8'h52;
        tick();
        s_iv = 0;
        #1 check("arst pre occ", 32'(s_occ), 32'(2));
        #1 rst_n = 1'b0;
        #1 check("arst out_valid", 32'(s_ov), 32'(0));
        check("arst out_data", 32'(s_od), 32'(BUB));
        check("arst in_ready", 32'(s_ir), 32'(1));
        check("arst occupancy", 32'(s_occ), 32'(0));
        #1 rst_n = 1'b1;
        #1 s_iv = 1; s_d = 8'h09; s_ordy = 1;
        tick();
        s_iv = 0;
        #1 check("arst push valid", 32'(s_ov), 32'(1));
        check("arst push data", 32'(s_od), 32'(8'h09));
        tick();
        #1 check("arst push drained", 32'(s_ov), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
